// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box frame sequencer.
// Optional empty-frame detection is enabled by defining BBOX_EMPTY_DET_EN.
package bbox_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        SETTLE
    } state_t;

    localparam int         BYTES_PER_PX = 3;
    localparam logic [7:0] DARK_THRESH  = 8'd250;
    localparam int         CLEAR_IDX    = 99999;

    typedef struct packed {
        logic [7:0] xmin;
        logic [7:0] xmax;
        logic [7:0] ymin;
        logic [7:0] ymax;
    } bbox_t;

    function automatic logic is_dark(input logic [7:0] value);
        return value < DARK_THRESH;
    endfunction

endpackage

// File: rtl/bbox_feed_pipe.sv
// One-stage alignment of RAM read data with its address for the box engine.
// Outside a valid write the index parks on CLEAR_IDX and the value on 8'hFF.
module bbox_feed_pipe #(
    parameter int AW        = 24,
    parameter int CLEAR_IDX = 99999
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_rd,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_rdata,
    input  logic          i_flush,
    output logic          o_wr_en,
    output logic [7:0]    o_value,
    output logic [AW-1:0] o_index
);
    import bbox_pkg::*;

    logic          r_wr_en;
    logic [AW-1:0] r_index;

    // Flush discards the read issued in the aborting cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en <= 1'b0;
            r_index <= AW'(CLEAR_IDX);
        end else if (i_flush || !i_rd) begin
            r_wr_en <= 1'b0;
            r_index <= AW'(CLEAR_IDX);
        end else begin
            r_wr_en <= 1'b1;
            r_index <= i_addr;
        end
    end

    assign o_wr_en = r_wr_en;
    assign o_value = r_wr_en ? i_rdata : 8'hFF;
    assign o_index = r_index;

endmodule

// File: rtl/bbox_frame_ctrl.sv
// Frame sequencer: clear engine, stream one raster frame, settle, capture box.
// Define BBOX_EMPTY_DET_EN to add res_empty and force an all-ones box on empty frames.
module bbox_frame_ctrl #(
    parameter int WIDTH     = 100,
    parameter int HEIGHT    = 100,
    parameter int CLEAR_IDX = bbox_pkg::CLEAR_IDX,
    parameter int AW        = 24
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic          box_wr_en,
    output logic [31:0]   box_value_index,
    input  logic [31:0]   box_result,
    output logic          res_valid,
    input  logic          res_ready,
`ifdef BBOX_EMPTY_DET_EN
    output logic          res_empty,
`endif
    output logic [31:0]   res_bbox
);
    import bbox_pkg::*;

    localparam int            NBYTES = BYTES_PER_PX * WIDTH * HEIGHT;
    localparam logic [AW-1:0] LAST   = AW'(NBYTES - 1);

    if (NBYTES - 1 >= CLEAR_IDX) begin : g_chk_clear_idx
        $error("bbox_frame_ctrl: frame byte index collides with CLEAR_IDX");
    end
    if (AW + 8 != 32) begin : g_chk_aw
        $error("bbox_frame_ctrl: AW must be 24 to fit box_value_index");
    end

    state_t        r_state;
    logic          r_busy;
    logic          r_mem_rd;
    logic [AW-1:0] r_rd_cnt;
    logic          r_res_valid;
    bbox_t         r_res_bbox;
    bbox_t         w_capture;
    logic          w_wr_en;
    logic [7:0]    w_value;
    logic [AW-1:0] w_index;

    bbox_feed_pipe #(
        .AW        (AW),
        .CLEAR_IDX (CLEAR_IDX)
    ) u_feed (
        .clk     (CLOCK_50),
        .rst_n   (reset_n),
        .i_rd    (r_mem_rd),
        .i_addr  (r_rd_cnt),
        .i_rdata (mem_rdata),
        .i_flush (abort),
        .o_wr_en (w_wr_en),
        .o_value (w_value),
        .o_index (w_index)
    );

`ifdef BBOX_EMPTY_DET_EN
    logic r_dark_seen;
    logic r_res_empty;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_dark_seen <= 1'b0;
        end else if (r_state == CLEAR) begin
            r_dark_seen <= 1'b0;
        end else if (w_wr_en && is_dark(w_value)) begin
            r_dark_seen <= 1'b1;
        end
    end

    assign w_capture = r_dark_seen ? bbox_t'(box_result) : bbox_t'(32'hFFFF_FFFF);
    assign res_empty = r_res_empty;
`else
    assign w_capture = bbox_t'(box_result);
`endif

    // Abort outranks every transition; the handshake clear runs independently.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_rd_cnt    <= '0;
            r_res_valid <= 1'b0;
            r_res_bbox  <= '0;
`ifdef BBOX_EMPTY_DET_EN
            r_res_empty <= 1'b0;
`endif
        end else begin
            if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
`ifdef BBOX_EMPTY_DET_EN
                r_res_empty <= 1'b0;
`endif
            end
            if (abort) begin
                r_state  <= IDLE;
                r_busy   <= 1'b0;
                r_mem_rd <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start && !r_res_valid) begin
                            r_state  <= CLEAR;
                            r_busy   <= 1'b1;
                            r_rd_cnt <= '0;
                        end
                    end
                    CLEAR: begin
                        r_state  <= STREAM;
                        r_mem_rd <= 1'b1;
                    end
                    STREAM: begin
                        if (r_rd_cnt == LAST) begin
                            r_state  <= DRAIN;
                            r_mem_rd <= 1'b0;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + AW'(1);
                        end
                    end
                    DRAIN: begin
                        r_state <= SETTLE;
                    end
                    SETTLE: begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_res_bbox  <= w_capture;
`ifdef BBOX_EMPTY_DET_EN
                        r_res_empty <= !r_dark_seen;
`endif
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_mem_rd <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy            = r_busy;
    assign mem_rd          = r_mem_rd;
    assign mem_addr        = r_rd_cnt;
    assign box_wr_en       = w_wr_en;
    assign box_value_index = {w_value, w_index};
    assign res_valid       = r_res_valid;
    assign res_bbox        = r_res_bbox;

endmodule

// File: tb/tb_bbox_frame_ctrl.sv
// Directed bench for bbox_frame_ctrl on a 48x48 frame with a behavioural RAM and box engine.
// Expectations follow BBOX_EMPTY_DET_EN when it is defined.
module tb_bbox_frame_ctrl;

    localparam int W    = 48;
    localparam int H    = 48;
    localparam int NB   = 3 * W * H;
    localparam int LAT  = NB + 3;
    localparam int CIDX = 99999;
`ifdef BBOX_EMPTY_DET_EN
    localparam logic [31:0] EMPTY_BOX = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] EMPTY_BOX = 32'h2F00_2F00;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        box_wr_en;
    logic [31:0] box_value_index;
    logic [31:0] box_result;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_bbox;
`ifdef BBOX_EMPTY_DET_EN
    logic        res_empty;
`endif

    bbox_frame_ctrl #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .CLEAR_IDX (CIDX),
        .AW        (24)
    ) dut (
        .CLOCK_50        (clk),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .busy            (busy),
        .mem_rd          (mem_rd),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .box_wr_en       (box_wr_en),
        .box_value_index (box_value_index),
        .box_result      (box_result),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
`ifdef BBOX_EMPTY_DET_EN
        .res_empty       (res_empty),
`endif
        .res_bbox        (res_bbox)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [NB];
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    // Engine model: clears on CLEAR_IDX, grows box on bytes below 250.
    logic [7:0] e_xmin, e_xmax, e_ymin, e_ymax;
    int px, ex, ey;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || box_value_index[23:0] == 24'(CIDX)) begin
            e_xmin <= 8'(W - 1); e_xmax <= 8'd0;
            e_ymin <= 8'(H - 1); e_ymax <= 8'd0;
        end else if (box_wr_en && box_value_index[31:24] < 8'd250) begin
            px = int'(box_value_index[23:0]) / 3;
            ex = px % W;
            ey = px / W;
            if (8'(ex) < e_xmin) e_xmin <= 8'(ex);
            if (8'(ex) > e_xmax) e_xmax <= 8'(ex);
            if (8'(ey) < e_ymin) e_ymin <= 8'(ey);
            if (8'(ey) > e_ymax) e_ymax <= 8'(ey);
        end
    end
    assign box_result = {e_xmin, e_xmax, e_ymin, e_ymax};

    // Feed-pipe monitor: every write must echo the previous cycle's read.
    int          wr_cnt = 0;
    int          mon_bad = 0;
    logic        prev_rd = 1'b0;
    logic [23:0] prev_addr = '0;
    always @(negedge clk) begin
        if (box_wr_en) begin
            wr_cnt++;
            if (!prev_rd || box_value_index[23:0] != prev_addr ||
                box_value_index[23:0] == 24'(CIDX) || !busy ||
                box_value_index[31:24] != ram[prev_addr])
                mon_bad++;
        end
        prev_rd   = mem_rd;
        prev_addr = mem_addr;
    end

    typedef struct {
        int          x0, y0;
        logic [7:0]  v0;
        int          x1, y1;
        logic [7:0]  v1;
        logic [31:0] box;
        logic        empty;
    } vec_t;
    vec_t tbl [6];

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_px(input int x, input int y, input logic [7:0] v);
        if (x >= 0)
            for (int b = 0; b < 3; b++) ram[(y * W + x) * 3 + b] = v;
    endtask

    task automatic load(input int e);
        for (int i = 0; i < NB; i++) ram[i] = 8'hFF;
        set_px(tbl[e].x0, tbl[e].y0, tbl[e].v0);
        set_px(tbl[e].x1, tbl[e].y1, tbl[e].v1);
    endtask

    task automatic start_frame();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("clear_busy", busy, 1);
        check("clear_no_rd", mem_rd, 0);
        check("clear_idx", box_value_index[23:0], 24'(CIDX));
    endtask

    task automatic ack();
        @(negedge clk) res_ready = 1'b1;
        @(negedge clk) res_ready = 1'b0;
        check("ack_clears", res_valid, 0);
    endtask

    task automatic run_frame(input int e, input bit do_ack);
        int cyc;
        int c0;
        load(e);
        c0 = wr_cnt;
        start_frame();
        cyc = 0;
        while (!res_valid && cyc < LAT + 100) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("latency_%0d", e), cyc, LAT);
        check($sformatf("wr_pulses_%0d", e), wr_cnt - c0, NB);
        check($sformatf("bbox_%0d", e), res_bbox, tbl[e].box);
        check($sformatf("idle_%0d", e), busy, 0);
`ifdef BBOX_EMPTY_DET_EN
        check($sformatf("empty_%0d", e), res_empty, tbl[e].empty);
`endif
        if (do_ack) ack();
    endtask

    initial begin
        bit stable;
        int n;

        tbl[0] = '{-1, -1, 8'h00, -1, -1, 8'h00, EMPTY_BOX,     1'b1};
        tbl[1] = '{10, 40, 8'h00, -1, -1, 8'h00, 32'h0A0A_2828, 1'b0};
        tbl[2] = '{ 0,  0, 8'h00, -1, -1, 8'h00, 32'h0000_0000, 1'b0};
        tbl[3] = '{47, 47, 8'h00, -1, -1, 8'h00, 32'h2F2F_2F2F, 1'b0};
        tbl[4] = '{ 5,  7, 8'h00, 40, 30, 8'h00, 32'h0528_071E, 1'b0};
        tbl[5] = '{20,  3, 8'd249, 1,  1, 8'd250, 32'h1414_0303, 1'b0};

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
        for (int i = 0; i < NB; i++) ram[i] = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wr", box_wr_en, 0);
        check("rst_vi", box_value_index, {8'hFF, 24'(CIDX)});
        check("rst_valid", res_valid, 0);
        check("rst_bbox", res_bbox, 0);
        reset_n = 1'b1;

        for (int e = 0; e < 6; e++) begin
            run_frame(e, e != 1);
            if (e == 1) begin
                stable = 1'b1;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    start = (i == 10);
                    if (res_bbox !== tbl[1].box || !res_valid || busy) stable = 1'b0;
                end
                start = 1'b0;
                check("hold_stable", stable, 1);
                ack();
            end
        end

        // Abort mid-stream, then a clean restart.
        load(2);
        start_frame();
        n = 0;
        while (!(mem_rd && mem_addr == 24'd1234) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached", mem_addr, 24'd1234);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort_rd", mem_rd, 0);
        check("abort_wr", box_wr_en, 0);
        check("abort_busy", busy, 0);
        repeat (20) @(negedge clk);
        check("abort_no_res", res_valid, 0);
        run_frame(1, 1);

        // Async reset mid-stream.
        load(0);
        start_frame();
        repeat (100) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rd", mem_rd, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_wr", box_wr_en, 0);
        check("arst_vi", box_value_index, {8'hFF, 24'(CIDX)});
        check("arst_valid", res_valid, 0);
        @(negedge clk) reset_n = 1'b1;
        run_frame(3, 1);

        // Start and abort together in IDLE.
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        check("sa_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("sa_busy_later", busy, 0);
        check("sa_rd", mem_rd, 0);

        check("feed_monitor", mon_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
